residual_add_stage: RTL and testbench
=====================================

RESIDUAL_ADD_STAGE -- requirements
Module: residual_add_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of every data sample, unsigned.
REQ-002 SHALL have parameter IN_CHANNELS, default 16: channels per frame.
REQ-003 SHALL have parameters IN_HEIGHT and IN_WIDTH, default 8 and 8: spatial frame size.
REQ-004 SHALL have parameter RESIDUAL_EN, default 1: 1 adds the shortcut; 0 passes the main stream through.
REQ-005 SHALL define FRAME_LEN = IN_CHANNELS*IN_HEIGHT*IN_WIDTH (default 1024), the number of samples per frame.
REQ-006 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port skip_data, input, DATA_WIDTH: shortcut (block input) sample.
REQ-009 SHALL have port skip_valid, input, 1 bit: skip_data is valid this cycle.
REQ-010 SHALL have port main_data, input, DATA_WIDTH: SE-scaled sample from the upstream SE stage.
REQ-011 SHALL have port main_valid, input, 1 bit: main_data is valid this cycle; no backpressure.
REQ-012 SHALL have port out_data, output, DATA_WIDTH: residual sum.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last out_valid of a frame.
REQ-015 SHALL have port err_underrun, output, 1 bit: sticky flag.
REQ-016 SHALL have port err_overrun, output, 1 bit: sticky flag.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL store skip samples in order at write index wr_idx, 0..FRAME_LEN-1, in a FRAME_LEN-deep buffer.
REQ-019 SHALL pair main sample k with stored skip sample k through read index rd_idx.
REQ-020 SHALL register out_data and out_valid with exactly 1-cycle latency from the accepted main_valid.
REQ-021 SHALL compute out_data = min(main + skip, 2^DATA_WIDTH-1), using a DATA_WIDTH+1-bit sum and unsigned saturation.
REQ-022 SHALL, when RESIDUAL_EN=0, set out_data = main_data delayed 1 cycle, ignore skip_valid, and keep the error flags at 0.
REQ-023 SHALL implement FSM states IDLE, FILL, READY, ADD.
REQ-024 SHALL transition IDLE->FILL on the first skip_valid.
REQ-025 SHALL transition FILL->READY when wr_idx reaches FRAME_LEN.
REQ-026 SHALL transition READY->ADD on the first main_valid.
REQ-027 SHALL transition ADD->IDLE after the main sample with rd_idx=FRAME_LEN-1, clearing wr_idx and rd_idx.
REQ-028 SHALL allow main samples during FILL, performing write and read in the same cycle, while rd_idx < wr_idx.
REQ-029 SHALL, when skip_valid and main_valid coincide with rd_idx == wr_idx, bypass skip_data directly into the adder and also write it to the buffer.
REQ-030 SHALL, on main_valid with rd_idx > wr_idx and no bypass, treat skip as 0, output main_data, and set err_underrun.
REQ-031 SHALL, on skip_valid while wr_idx == FRAME_LEN (states READY/ADD), drop the sample and set err_overrun.
REQ-032 SHALL assert frame_done together with out_valid for rd_idx = FRAME_LEN-1 only.
REQ-033 SHALL drive out_valid low in every cycle without an accepted main sample.
REQ-034 SHALL count main samples received in IDLE as frame index 0, entering ADD directly, with the underrun rule applied.

Reset
REQ-035 SHALL, on asynchronous rst assertion, return the FSM to IDLE.
REQ-036 SHALL, on rst, clear wr_idx, rd_idx, out_data, out_valid, frame_done, err_underrun, err_overrun, and busy to 0.
REQ-037 SHALL not require the buffer contents to be cleared on reset.
REQ-038 SHALL discard any partial frame when rst is asserted mid-frame and SHALL emit no output until new samples arrive.
REQ-039 SHALL clear the sticky flags only on rst.

Structure
REQ-040 SHALL place the FSM state enum and the FRAME_LEN computation function in shared package mnv3_pkg.
REQ-041 SHALL implement the buffer as sub-module skip_buffer: simple dual-port, 1 write and 1 read port, synchronous write, combinational read, DEPTH=FRAME_LEN.
REQ-042 SHALL use index widths of $clog2(FRAME_LEN)+1 bits.

Verification
REQ-043 SHALL cover: 1024 skip samples = 100, then 1024 main samples = 200 -> 1024 outputs of 300 one cycle after each main, frame_done on the last output only, FSM back in IDLE.
REQ-044 SHALL cover: skip = 65000, main = 1000 -> out_data = 65535 (saturation), no error flags.
REQ-045 SHALL cover: skip and main both valid every cycle from index 0 (bypass path), skip = i, main = 1 -> out = i+1 for all i, err_underrun stays 0.
REQ-046 SHALL cover: main_valid at index 5 with only 3 skip samples stored -> out = main_data, err_underrun = 1 and held until rst.
REQ-047 SHALL cover: 1025th skip sample in READY -> dropped, err_overrun = 1, the following frame's sums unaffected.
REQ-048 SHALL cover: rst asserted after 500 main samples -> all outputs 0 immediately; next full frame produces correct sums starting from index 0.

Source files
------------

// File: rtl/mnv3_pkg.sv
// Shared definitions for the MobileNetV3 block datapath: residual-stage FSM
// encoding and the frame-size helper.
package mnv3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_ADD   = 2'd3
  } res_state_t;

  function automatic int frame_len(input int channels, input int height, input int width);
    return channels * height * width;
  endfunction

endpackage

// File: rtl/skip_buffer.sv
// Frame-deep shortcut store: one synchronous write port, one combinational
// read port. Contents are not reset.
module skip_buffer #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/residual_add_stage.sv
// Residual add: buffers one frame of shortcut samples and adds them, with
// unsigned saturation, to the SE-scaled main stream in arrival order.
module residual_add_stage
  import mnv3_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IN_CHANNELS = 16,
  parameter int IN_HEIGHT   = 8,
  parameter int IN_WIDTH    = 8,
  parameter int RESIDUAL_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] skip_data,
  input  logic                  skip_valid,
  input  logic [DATA_WIDTH-1:0] main_data,
  input  logic                  main_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  frame_done,
  output logic                  err_underrun,
  output logic                  err_overrun,
  output logic                  busy
);

  localparam int FRAME_LEN = frame_len(IN_CHANNELS, IN_HEIGHT, IN_WIDTH);
  localparam int IDX_W     = $clog2(FRAME_LEN) + 1;
  localparam int ADDR_W    = IDX_W - 1;
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam bit RES_ON = (RESIDUAL_EN != 0);

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
  endfunction

  res_state_t            state, state_nxt;
  logic [IDX_W-1:0]      wr_idx, rd_idx, wr_nxt, rd_nxt;
  logic                  skip_in, wr_en, overrun, bypass, stored, underrun, last;
  logic [DATA_WIDTH-1:0] rd_data, skip_sel;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1, done_p1;

  skip_buffer #(
    .DEPTH     (FRAME_LEN),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_skip_buffer (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_idx[ADDR_W-1:0]),
    .wdata(skip_data),
    .raddr(rd_idx[ADDR_W-1:0]),
    .rdata(rd_data)
  );

  always_comb begin
    skip_in  = RES_ON && skip_valid;
    wr_en    = skip_in && (wr_idx != FULL_IDX);
    overrun  = skip_in && (wr_idx == FULL_IDX);
    // Shortcut sample arriving exactly when it is needed skips the buffer.
    bypass   = wr_en && main_valid && (rd_idx == wr_idx);
    stored   = rd_idx < wr_idx;
    underrun = RES_ON && main_valid && !bypass && !stored;
    last     = main_valid && (rd_idx == LAST_IDX);

    skip_sel = '0;
    if (bypass)               skip_sel = skip_data;
    else if (RES_ON && stored) skip_sel = rd_data;

    wr_nxt    = wr_idx + {{(IDX_W-1){1'b0}}, wr_en};
    rd_nxt    = rd_idx + {{(IDX_W-1){1'b0}}, main_valid};
    state_nxt = state;
    case (state)
      ST_IDLE:  if (main_valid) state_nxt = ST_ADD;
                else if (skip_in) state_nxt = ST_FILL;
      ST_FILL:  if (wr_nxt == FULL_IDX) state_nxt = ST_READY;
      ST_READY: if (main_valid) state_nxt = ST_ADD;
      ST_ADD:   state_nxt = ST_ADD;
      default:  state_nxt = ST_IDLE;
    endcase
    if (last) begin
      state_nxt = ST_IDLE;
      wr_nxt    = '0;
      rd_nxt    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      state  <= state_nxt;
      wr_idx <= wr_nxt;
      rd_idx <= rd_nxt;
    end
  end

  // ---- stage p1: registered sum, valid and flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1      <= '0;
      vld_p1       <= 1'b0;
      done_p1      <= 1'b0;
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      data_p1 <= main_valid ? sat_add(main_data, skip_sel) : '0;
      vld_p1  <= main_valid;
      done_p1 <= last;
      if (underrun) err_underrun <= 1'b1;
      if (overrun)  err_overrun  <= 1'b1;
    end
  end

  assign out_data   = data_p1;
  assign out_valid  = vld_p1;
  assign frame_done = done_p1;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_residual_add_stage.sv
// Directed bench for residual_add_stage at default parameters (1024-sample frames).
module tb_residual_add_stage;

  localparam int DW = 16;
  localparam int FL = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] skip_data = '0;
  logic          skip_valid = 1'b0;
  logic [DW-1:0] main_data = '0;
  logic          main_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid, frame_done, err_underrun, err_overrun, busy;

  int n_vec = 0;
  int n_err = 0;

  residual_add_stage dut (
    .clk         (clk),
    .rst         (rst),
    .skip_data   (skip_data),
    .skip_valid  (skip_valid),
    .main_data   (main_data),
    .main_valid  (main_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .frame_done  (frame_done),
    .err_underrun(err_underrun),
    .err_overrun (err_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic cyc(input logic sv, input int sd, input logic mv, input int md);
    skip_valid = sv;
    skip_data  = DW'(sd);
    main_valid = mv;
    main_data  = DW'(md);
    @(posedge clk);
    #1;
    skip_valid = 1'b0;
    main_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int i, input int exp_d);
    chk($sformatf("%s_vld[%0d]", tag, i), out_valid, 1);
    chk($sformatf("%s_data[%0d]", tag, i), out_data, exp_d);
    chk($sformatf("%s_done[%0d]", tag, i), frame_done, (i == FL - 1) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_data", out_data, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_unr", err_underrun, 0);
    chk("rst_ovr", err_overrun, 0);
    chk("rst_busy", busy, 0);

    // Plain frame: 100 + 200.
    for (int i = 0; i < FL; i++) begin
      cyc(1, 100, 0, 0);
      if (i == 0) chk("fill_busy", busy, 1);
      if (i < 4) chk($sformatf("fill_vld[%0d]", i), out_valid, 0);
    end
    for (int i = 0; i < FL; i++) begin
      cyc(0, 0, 1, 200);
      chk_out("sum", i, 300);
    end
    chk("sum_idle_busy", busy, 0);
    cyc(0, 0, 0, 0);
    chk("sum_gap_vld", out_valid, 0);
    chk("sum_gap_done", frame_done, 0);

    // Saturation: 65000 + {1000, 535, 534}.
    for (int i = 0; i < FL; i++) cyc(1, 65000, 0, 0);
    for (int i = 0; i < FL; i++) begin
      int m, e;
      m = (i % 3 == 0) ? 1000 : (i % 3 == 1) ? 535 : 534;
      e = (i % 3 == 2) ? 65534 : 65535;
      cyc(0, 0, 1, m);
      chk_out("sat", i, e);
    end
    chk("sat_unr", err_underrun, 0);
    chk("sat_ovr", err_overrun, 0);

    // Bypass: skip and main together every cycle.
    for (int i = 0; i < FL; i++) begin
      cyc(1, i, 1, 1);
      chk_out("byp", i, i + 1);
    end
    chk("byp_unr", err_underrun, 0);
    chk("byp_busy", busy, 0);

    // Overrun: extra skip in READY is dropped.
    for (int i = 0; i < FL; i++) cyc(1, i, 0, 0);
    chk("ovr_pre", err_overrun, 0);
    cyc(1, 9999, 0, 0);
    chk("ovr_set", err_overrun, 1);
    chk("ovr_busy", busy, 1);
    for (int i = 0; i < FL; i++) begin
      cyc(0, 0, 1, 5);
      chk_out("ovr", i, i + 5);
    end
    chk("ovr_hold", err_overrun, 1);
    chk("ovr_unr", err_underrun, 0);

    // Mid-frame reset.
    do_reset();
    chk("rst2_ovr", err_overrun, 0);
    for (int i = 0; i < FL; i++) cyc(1, 7, 0, 0);
    for (int i = 0; i < 500; i++) begin
      cyc(0, 0, 1, 3);
      if (i % 50 == 0 || i == 499) chk_out("pre", i, 10);
    end
    rst = 1'b1;
    #1;
    chk("arst_data", out_data, 0);
    chk("arst_vld", out_valid, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk("arst_idle_vld", out_valid, 0);
    chk("arst_idle_busy", busy, 0);
    for (int i = 0; i < FL; i++) cyc(1, 2 * i, 0, 0);
    for (int i = 0; i < FL; i++) begin
      cyc(0, 0, 1, 1);
      chk_out("post", i, 2 * i + 1);
    end
    chk("post_unr", err_underrun, 0);

    // Underrun: 3 skips stored, 6 mains.
    do_reset();
    cyc(1, 10, 0, 0);
    cyc(1, 20, 0, 0);
    cyc(1, 30, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 50);
      chk($sformatf("unr_data[%0d]", i), out_data, (i < 3) ? 60 + 10 * i : 50);
      chk($sformatf("unr_flag[%0d]", i), err_underrun, (i < 3) ? 0 : 1);
    end
    repeat (5) cyc(0, 0, 0, 0);
    chk("unr_hold", err_underrun, 1);
    chk("unr_ovr", err_overrun, 0);
    do_reset();
    chk("unr_clr", err_underrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
